// File: rtl/mux_sel_scheduler.sv
// mux_sel_scheduler
//   Round-robin scheduler driving the 2-bit select of a registered 4:1
//   channel mux. One channel is granted at a time for a programmable burst.
//   A burst ends early if the owner drops its request. The last winner has
//   the lowest priority in the next arbitration.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   arbitration enable (never cuts an active burst short)
//   req      in   per-channel request, bit i = channel i
//   burst    in   grant length in cycles, sampled at the grant edge (0 -> 1)
//   sel      out  registered mux select, holds while idle
//   gnt      out  registered one-hot grant, zero while idle
//   busy     out  high while a grant is active
//   done     out  one-cycle pulse after a burst's last grant cycle
//   done_ch  out  channel of the completed burst, holds between pulses
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no grant; waiting for en=1 and any request
// GRANT | channel sel owns the mux; cnt = cycles left (incl. current)

module mux_sel_scheduler #(
    parameter int BW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    req,
    input  logic [BW-1:0] burst,
    output logic [1:0]    sel,
    output logic [3:0]    gnt,
    output logic          busy,
    output logic          done,
    output logic [1:0]    done_ch
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          done_q, done_d;
    logic [1:0]    done_ch_q, done_ch_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [BW-1:0] cnt_q, cnt_d;

    logic          win_found;
    logic [1:0]    win;
    logic [1:0]    cand;
    logic          burst_end;
    logic [BW-1:0] burst_len;

    // Search ptr+1 .. ptr+4; the last step wraps onto ptr itself so a lone
    // requester can win again.
    always_comb begin
        win_found = 1'b0;
        win       = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    assign burst_len = (burst == '0) ? BW'(1) : burst;
    // cnt <= 1 instead of == 1 keeps the counter from ever wrapping.
    assign burst_end = (cnt_q <= BW'(1)) || !req[sel_q];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        done_d    = 1'b0;
        done_ch_d = done_ch_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        if (state_q == GRANT && !burst_end) begin
            cnt_d = cnt_q - BW'(1);
        end else begin
            if (state_q == GRANT) begin
                done_d    = 1'b1;
                done_ch_d = sel_q;
            end
            // ptr_q equals sel_q during GRANT, so the search starts from
            // the channel that just finished.
            if (en && win_found) begin
                state_d = GRANT;
                sel_d   = win;
                gnt_d   = 4'b0001 << win;
                ptr_d   = win;
                cnt_d   = burst_len;
            end else begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            done_q    <= 1'b0;
            done_ch_q <= 2'd0;
            ptr_q     <= 2'd3;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_ch_q <= done_ch_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign busy    = |gnt_q;
    assign done    = done_q;
    assign done_ch = done_ch_q;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
module tb_mux_sel_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] burst;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       done;
    logic [1:0] done_ch;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which channel owns the mux (-1 = nobody), how many
    // grant cycles it has left, and who won last.
    int m_owner, m_left, m_last, m_sel, m_done, m_done_ch;

    mux_sel_scheduler #(.BW(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .burst(burst),
        .sel(sel), .gnt(gnt), .busy(busy), .done(done), .done_ch(done_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_last = 3; m_sel = 0; m_done = 0; m_done_ch = 0;
    endtask

    task automatic model_try_grant();
        if (en && req != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_sel   = c;
                    m_left  = (burst == 0) ? 1 : int'(burst);
                    break;
                end
            end
        end
    endtask

    task automatic model_step();
        m_done = 0;
        if (m_owner >= 0) begin
            if (m_left == 1 || !req[m_owner]) begin
                m_done    = 1;
                m_done_ch = m_owner;
                m_owner   = -1;
                model_try_grant();
            end else begin
                m_left--;
            end
        end else begin
            model_try_grant();
        end
    endtask

    task automatic compare_all();
        chk("sel",     32'(sel),     32'(m_sel));
        chk("gnt",     32'(gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy",    32'(busy),    32'(m_owner >= 0));
        chk("done",    32'(done),    32'(m_done));
        chk("done_ch", 32'(done_ch), 32'(m_done_ch));
    endtask

    // One clock: model follows the edge, compare shortly after, return at
    // the falling edge where the caller may change inputs.
    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    // Reset pulse that starts off the clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int sel_seq[5];
        int gnt_cycles;

        rst = 1'b1; en = 1'b0; req = 4'b0000; burst = 4'd0;
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Sole requester, burst 3, re-granted back to back.
        en = 1'b1; req = 4'b0001; burst = 4'd3;
        gnt_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (gnt == 4'b0001 && !done) gnt_cycles++;
        end
        chk("t1_gnt_cycles", 32'(gnt_cycles), 32'd3);
        cyc();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_ch", 32'(done_ch), 32'd0);
        chk("t1_regrant", 32'(gnt), 32'b0001);

        // Full rotation with burst 1.
        async_reset();
        req = 4'b1111; burst = 4'd1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            sel_seq[i] = int'(sel);
            chk("t2_busy", 32'(busy), 32'd1);
            if (i > 0) chk("t2_done", 32'(done), 32'd1);
        end
        chk("t2_rot0", 32'(sel_seq[0]), 32'd0);
        chk("t2_rot1", 32'(sel_seq[1]), 32'd1);
        chk("t2_rot2", 32'(sel_seq[2]), 32'd2);
        chk("t2_rot3", 32'(sel_seq[3]), 32'd3);
        chk("t2_rot4", 32'(sel_seq[4]), 32'd0);

        // Two requesters alternate: 0, 2, 0.
        async_reset();
        req = 4'b0101; burst = 4'd2;
        for (int i = 0; i < 7; i++) cyc();
        chk("t3_done_ch", 32'(done_ch), 32'd0);
        chk("t3_sel", 32'(sel), 32'd2);

        // Early release on third grant cycle of channel 1.
        async_reset();
        req = 4'b0010; burst = 4'd8;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_gnt", 32'(gnt), 32'b0010);
        end
        req = 4'b0000;
        cyc();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_done_ch", 32'(done_ch), 32'd1);
        chk("t4_idle", 32'(gnt), 32'd0);
        cyc();
        chk("t4_sel_hold", 32'(sel), 32'd1);

        // en dropped during a burst of 4.
        async_reset();
        req = 4'b1111; burst = 4'd4;
        cyc();
        cyc();
        en = 1'b0;
        cyc(); cyc();
        chk("t5_still", 32'(gnt), 32'b0001);
        cyc();
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_nogrant", 32'(gnt), 32'd0);
        for (int i = 0; i < 3; i++) cyc();
        en = 1'b1;
        cyc();
        chk("t5_resume", 32'(gnt), 32'b0010);

        // Reset mid-burst, then burst 0 behaves as a single cycle.
        req = 4'b1111; burst = 4'd5;
        cyc();
        async_reset();
        burst = 4'd0;
        cyc();
        chk("t6_first", 32'(gnt), 32'b0001);
        cyc();
        chk("t6_len1", 32'(gnt), 32'b0010);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom);
            if ($urandom_range(0, 9) == 0) req = 4'b0000;
            en    = ($urandom_range(0, 7) != 0);
            burst = 4'($urandom);
            if ($urandom_range(0, 299) == 0) async_reset();
            else cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
